tile_grid_ctrl: RTL and testbench

- Owns the level's tile grid and is the source side of the tile-drawing interface.
- Converts the VGA scan position into tile type plus in-tile offsets for the tile drawer.
- Loads levels from a constant level table.
- Services ball-hit requests that clear collected gift tiles and maintains the remaining-gift count.

---
 rtl/tile_pkg.sv | 63 ++++++
 rtl/tile_locator.sv | 35 +++
 rtl/tile_grid_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_tile_grid_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared tile-grid types, geometry constants and the constant level table.
package tile_pkg;

  localparam int unsigned TILE_W     = 80;
  localparam int unsigned TILE_H     = 80;
  localparam int unsigned COLS       = 8;
  localparam int unsigned ROWS       = 6;
  localparam int unsigned CELLS      = ROWS * COLS;
  localparam int unsigned SCREEN_W   = 640;
  localparam int unsigned SCREEN_H   = 480;
  localparam int unsigned NUM_LEVELS = 4;
  localparam int unsigned PIX_W      = 11;
  localparam int unsigned COL_W      = $clog2(COLS);
  localparam int unsigned ROW_W      = $clog2(ROWS);
  localparam int unsigned IDX_W      = $clog2(CELLS);
  localparam int unsigned LVL_W      = 2;
  localparam int unsigned GCNT_W     = 6;

  typedef enum logic [1:0] {
    BACKGROUND = 2'b00,
    FLOOR      = 2'b01,
    GIFT       = 2'b10
  } tile_t;

  // Short aliases keep the level table readable.
  localparam tile_t BG = BACKGROUND;
  localparam tile_t FL = FLOOR;
  localparam tile_t GF = GIFT;

  // Row-major level layouts, one row of 8 cells per line.
  localparam tile_t LEVEL_TABLE [NUM_LEVELS][CELLS] = '{
    '{BG, BG, BG, BG, BG, BG, BG, BG,
      BG, BG, BG, BG, BG, BG, BG, BG,
      BG, BG, BG, GF, BG, BG, BG, BG,
      BG, BG, FL, FL, FL, FL, BG, BG,
      BG, BG, BG, BG, BG, BG, GF, BG,
      FL, FL, FL, FL, FL, FL, FL, FL},
    '{BG, BG, BG, BG, BG, BG, BG, GF,
      BG, GF, BG, BG, BG, BG, BG, BG,
      FL, FL, FL, FL, BG, BG, BG, BG,
      BG, BG, BG, BG, BG, BG, GF, BG,
      BG, BG, BG, BG, FL, FL, FL, FL,
      FL, FL, FL, FL, FL, FL, FL, FL},
    '{BG, BG, BG, BG, BG, BG, BG, BG,
      BG, BG, BG, GF, BG, BG, BG, BG,
      BG, FL, FL, FL, FL, FL, FL, BG,
      BG, BG, BG, BG, BG, BG, BG, BG,
      GF, BG, GF, BG, GF, BG, GF, BG,
      FL, FL, FL, FL, FL, FL, FL, FL},
    '{GF, GF, GF, GF, GF, GF, GF, GF,
      BG, BG, BG, BG, BG, BG, BG, BG,
      BG, BG, BG, BG, BG, BG, BG, BG,
      FL, FL, BG, BG, BG, BG, FL, FL,
      BG, BG, BG, BG, BG, BG, BG, BG,
      FL, FL, FL, FL, FL, FL, FL, FL}
  };

  // The reserved code 2'b11 is never stored; it collapses to BACKGROUND.
  function automatic tile_t sanitize(input logic [1:0] code);
    return (code == 2'b11) ? BACKGROUND : tile_t'(code);
  endfunction

endpackage

// File: rtl/tile_locator.sv
// Pure combinational pixel -> tile row/col and in-tile offset, via comparator chains.
module tile_locator
  import tile_pkg::*;
(
  input  logic [PIX_W-1:0] pix_x_i,
  input  logic [PIX_W-1:0] pix_y_i,
  output logic [ROW_W-1:0] row_c_o,
  output logic [COL_W-1:0] col_c_o,
  output logic [PIX_W-1:0] off_x_c_o,
  output logic [PIX_W-1:0] off_y_c_o,
  output logic             on_screen_c_o
);

  logic [ROW_W-1:0] row_c;
  logic [COL_W-1:0] col_c;

  // Count tile boundaries at or left of / above the pixel.
  always_comb begin
    col_c = '0;
    row_c = '0;
    for (int unsigned k = 1; k < COLS; k++) begin
      if (pix_x_i >= PIX_W'(k * TILE_W)) col_c = col_c + COL_W'(1);
    end
    for (int unsigned k = 1; k < ROWS; k++) begin
      if (pix_y_i >= PIX_W'(k * TILE_H)) row_c = row_c + ROW_W'(1);
    end
  end

  assign row_c_o       = row_c;
  assign col_c_o       = col_c;
  assign off_x_c_o     = pix_x_i - PIX_W'(32'(col_c) * TILE_W);
  assign off_y_c_o     = pix_y_i - PIX_W'(32'(row_c) * TILE_H);
  assign on_screen_c_o = (32'(pix_x_i) < SCREEN_W) && (32'(pix_y_i) < SCREEN_H);

endmodule

// File: rtl/tile_grid_ctrl.sv
// Tile grid owner: display lookup, level loading and ball-hit gift clearing.
module tile_grid_ctrl
  import tile_pkg::*;
(
  input  logic              clk,
  input  logic              resetN,
  input  logic [PIX_W-1:0]  pixelX,
  input  logic [PIX_W-1:0]  pixelY,
  output logic [PIX_W-1:0]  offsetX,
  output logic [PIX_W-1:0]  offsetY,
  output logic [1:0]        Tile_type,
  input  logic              loadLevel,
  input  logic [LVL_W-1:0]  levelSel,
  input  logic              hitReq,
  input  logic [PIX_W-1:0]  hitX,
  input  logic [PIX_W-1:0]  hitY,
  output logic              hitAck,
  output logic              giftCollected,
  output logic              busy,
  output logic [GCNT_W-1:0] giftsLeft
);

  typedef enum logic [1:0] {SERVE, LOAD, HIT_RD, HIT_WR} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    load_idx_q, load_idx_d;
  logic [LVL_W-1:0]    lvl_q, lvl_d;
  logic [GCNT_W-1:0]   gifts_q, gifts_d;
  logic [IDX_W-1:0]    hit_idx_q, hit_idx_d;
  logic                hit_on_q, hit_on_d;
  logic                ack_q, ack_d;
  logic                gcol_q, gcol_d;
  logic                busy_q, busy_d;
  tile_t               grid_q [CELLS];
  tile_t               tile_q;
  logic [PIX_W-1:0]    off_x_q, off_y_q;

  logic                wr_en_c;
  logic [IDX_W-1:0]    wr_idx_c;
  tile_t               wr_val_c;

  logic [ROW_W-1:0]    disp_row, hit_row;
  logic [COL_W-1:0]    disp_col, hit_col;
  logic [PIX_W-1:0]    disp_off_x, disp_off_y;
  logic [PIX_W-1:0]    hit_off_x_unused, hit_off_y_unused;
  logic                disp_on, hit_on;
  logic [IDX_W-1:0]    disp_idx, hit_idx;

  tile_locator u_disp_loc (
    .pix_x_i       (pixelX),
    .pix_y_i       (pixelY),
    .row_c_o       (disp_row),
    .col_c_o       (disp_col),
    .off_x_c_o     (disp_off_x),
    .off_y_c_o     (disp_off_y),
    .on_screen_c_o (disp_on)
  );

  tile_locator u_hit_loc (
    .pix_x_i       (hitX),
    .pix_y_i       (hitY),
    .row_c_o       (hit_row),
    .col_c_o       (hit_col),
    .off_x_c_o     (hit_off_x_unused),
    .off_y_c_o     (hit_off_y_unused),
    .on_screen_c_o (hit_on)
  );

  assign disp_idx = IDX_W'(32'(disp_row) * COLS + 32'(disp_col));
  assign hit_idx  = IDX_W'(32'(hit_row) * COLS + 32'(hit_col));

  // Next-state, load sequencing, hit servicing and the single grid write port.
  always_comb begin
    state_d    = state_q;
    load_idx_d = load_idx_q;
    lvl_d      = lvl_q;
    gifts_d    = gifts_q;
    hit_idx_d  = hit_idx_q;
    hit_on_d   = hit_on_q;
    ack_d      = 1'b0;
    gcol_d     = 1'b0;
    wr_en_c    = 1'b0;
    wr_idx_c   = '0;
    wr_val_c   = BACKGROUND;
    unique case (state_q)
      SERVE: begin
        if (loadLevel) begin
          state_d    = LOAD;
          load_idx_d = '0;
          gifts_d    = '0;
          lvl_d      = levelSel;
        end else if (hitReq) begin
          state_d = HIT_RD;
        end
      end
      LOAD: begin
        wr_en_c  = 1'b1;
        wr_idx_c = load_idx_q;
        wr_val_c = sanitize(LEVEL_TABLE[lvl_q][load_idx_q]);
        if (wr_val_c == GIFT) gifts_d = gifts_q + GCNT_W'(1);
        if (load_idx_q == IDX_W'(CELLS - 1)) begin
          state_d = SERVE;
        end else begin
          load_idx_d = load_idx_q + IDX_W'(1);
        end
      end
      HIT_RD: begin
        hit_idx_d = hit_idx;
        hit_on_d  = hit_on;
        state_d   = HIT_WR;
      end
      HIT_WR: begin
        ack_d   = 1'b1;
        state_d = SERVE;
        if (hit_on_q && (grid_q[hit_idx_q] == GIFT)) begin
          wr_en_c  = 1'b1;
          wr_idx_c = hit_idx_q;
          wr_val_c = BACKGROUND;
          gcol_d   = 1'b1;
          if (gifts_q != '0) gifts_d = gifts_q - GCNT_W'(1);
        end
      end
      default: state_d = SERVE;
    endcase
    busy_d = (state_d == LOAD) || (state_d == HIT_WR);
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q    <= SERVE;
      load_idx_q <= '0;
      lvl_q      <= '0;
      gifts_q    <= '0;
      hit_idx_q  <= '0;
      hit_on_q   <= 1'b0;
      ack_q      <= 1'b0;
      gcol_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_idx_q <= load_idx_d;
      lvl_q      <= lvl_d;
      gifts_q    <= gifts_d;
      hit_idx_q  <= hit_idx_d;
      hit_on_q   <= hit_on_d;
      ack_q      <= ack_d;
      gcol_q     <= gcol_d;
      busy_q     <= busy_d;
    end
  end

  // Grid storage: cleared on reset, one cell written per cycle at most.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < CELLS; i++) grid_q[i] <= BACKGROUND;
    end else if (wr_en_c) begin
      grid_q[wr_idx_c] <= wr_val_c;
    end
  end

  // Display path: one-cycle registered lookup, blanked off-screen and during loads.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      tile_q  <= BACKGROUND;
      off_x_q <= '0;
      off_y_q <= '0;
    end else if (disp_on) begin
      tile_q  <= (state_q == LOAD) ? BACKGROUND : grid_q[disp_idx];
      off_x_q <= disp_off_x;
      off_y_q <= disp_off_y;
    end else begin
      tile_q  <= BACKGROUND;
      off_x_q <= '0;
      off_y_q <= '0;
    end
  end

  assign Tile_type     = tile_q;
  assign offsetX       = off_x_q;
  assign offsetY       = off_y_q;
  assign hitAck        = ack_q;
  assign giftCollected = gcol_q;
  assign busy          = busy_q;
  assign giftsLeft     = gifts_q;

endmodule

// File: tb/tb_tile_grid_ctrl.sv
// Scoreboard bench for tile_grid_ctrl with a division-based reference grid model.
module tb_tile_grid_ctrl;
  import tile_pkg::*;

  logic              clk = 1'b0;
  logic              resetN;
  logic [PIX_W-1:0]  pixelX, pixelY, hitX, hitY;
  logic [PIX_W-1:0]  offsetX, offsetY;
  logic [1:0]        Tile_type;
  logic              loadLevel, hitReq, hitAck, giftCollected, busy;
  logic [LVL_W-1:0]  levelSel;
  logic [GCNT_W-1:0] giftsLeft;

  always #5 clk = ~clk;

  tile_grid_ctrl dut (
    .clk           (clk),
    .resetN        (resetN),
    .pixelX        (pixelX),
    .pixelY        (pixelY),
    .offsetX       (offsetX),
    .offsetY       (offsetY),
    .Tile_type     (Tile_type),
    .loadLevel     (loadLevel),
    .levelSel      (levelSel),
    .hitReq        (hitReq),
    .hitX          (hitX),
    .hitY          (hitY),
    .hitAck        (hitAck),
    .giftCollected (giftCollected),
    .busy          (busy),
    .giftsLeft     (giftsLeft)
  );

  localparam int T_BG = 0, T_FL = 1, T_GF = 2;

  typedef struct { int tile; int ox; int oy; } disp_exp_t;
  typedef struct { int gc; int gifts; } hit_exp_t;

  disp_exp_t disp_q[$];
  hit_exp_t  hit_q[$];
  int        gm [6][8];
  int        gifts_m = 0;
  int        n_chk = 0;
  int        n_pass = 0;
  logic      pix_chk = 1'b0;
  logic      mon_v;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int lvl_cell(input int lvl, input int r, input int c);
    if (lvl == 0) begin
      if (r == 5) return T_FL;
      if (r == 3 && c >= 2 && c <= 5) return T_FL;
      if ((r == 2 && c == 3) || (r == 4 && c == 6)) return T_GF;
      return T_BG;
    end
    return int'(LEVEL_TABLE[lvl][r*8 + c]);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 6; r++) for (int c = 0; c < 8; c++) gm[r][c] = T_BG;
    gifts_m = 0;
  endtask

  task automatic model_load(input int lvl);
    gifts_m = 0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 8; c++) begin
        gm[r][c] = lvl_cell(lvl, r, c);
        if (gm[r][c] == T_GF) gifts_m++;
      end
  endtask

  function automatic disp_exp_t model_pix(input int x, input int y, input bit loading);
    disp_exp_t e;
    if (x >= 640 || y >= 480) begin
      e.tile = T_BG; e.ox = 0; e.oy = 0;
    end else begin
      e.ox   = x % 80;
      e.oy   = y % 80;
      e.tile = loading ? T_BG : gm[y / 80][x / 80];
    end
    return e;
  endfunction

  task automatic model_hit(input int x, input int y, output hit_exp_t e);
    e.gc = 0;
    if (x < 640 && y < 480 && gm[y / 80][x / 80] == T_GF) begin
      gm[y / 80][x / 80] = T_BG;
      if (gifts_m > 0) gifts_m--;
      e.gc = 1;
    end
    e.gifts = gifts_m;
  endtask

  // ---------------- monitors ----------------
  always begin
    disp_exp_t e;
    @(posedge clk);
    mon_v = pix_chk;
    #1;
    if (mon_v) begin
      check("disp_queue_empty", int'(disp_q.size() == 0), 0);
      if (disp_q.size() != 0) begin
        e = disp_q.pop_front();
        check("Tile_type", int'(Tile_type), e.tile);
        check("offsetX", int'(offsetX), e.ox);
        check("offsetY", int'(offsetY), e.oy);
      end
    end
  end

  always begin
    hit_exp_t e;
    @(posedge clk);
    #1;
    if (hitAck) begin
      check("ack_expected", int'(hit_q.size() != 0), 1);
      if (hit_q.size() != 0) begin
        e = hit_q.pop_front();
        check("giftCollected", int'(giftCollected), e.gc);
        check("giftsLeft_after_hit", int'(giftsLeft), e.gifts);
      end
    end
    if (giftCollected && !hitAck) check("gc_without_ack", int'(giftCollected), int'(hitAck));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    pix_chk = 1'b0;
  endtask

  task automatic drive_pix(input int x, input int y, input bit loading);
    pixelX  = PIX_W'(x);
    pixelY  = PIX_W'(y);
    pix_chk = 1'b1;
    disp_q.push_back(model_pix(x, y, loading));
  endtask

  task automatic show(input int x, input int y);
    tick();
    drive_pix(x, y, 1'b0);
    tick();
  endtask

  task automatic sweep();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 8; c++) begin
        tick();
        drive_pix(c*80 + int'($urandom_range(0, 79)), r*80 + int'($urandom_range(0, 79)), 1'b0);
      end
    tick();
  endtask

  task automatic do_load(input int lvl);
    int n;
    tick();
    loadLevel = 1'b1;
    levelSel  = LVL_W'(lvl);
    tick();
    loadLevel = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if ($urandom_range(0, 3) == 0)
        drive_pix(int'($urandom_range(0, 719)), int'($urandom_range(0, 539)), 1'b1);
      loadLevel = ($urandom_range(0, 7) == 0);
      levelSel  = LVL_W'($urandom_range(0, 3));
      tick();
    end
    loadLevel = 1'b0;
    check("load_busy_cycles", n, 48);
    model_load(lvl);
    check("giftsLeft_after_load", int'(giftsLeft), gifts_m);
  endtask

  task automatic do_hit(input int x, input int y);
    hit_exp_t e;
    int lat;
    bit seen;
    model_hit(x, y, e);
    hit_q.push_back(e);
    tick();
    hitReq = 1'b1;
    hitX   = PIX_W'(x);
    hitY   = PIX_W'(y);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      tick();
      lat++;
      if (lat == 1) check("busy_in_hit_rd", int'(busy), 0);
      if (lat == 2) check("busy_in_hit_wr", int'(busy), 1);
      if (hitAck) seen = 1;
    end
    hitReq = 1'b0;
    check("hit_ack_latency", lat, 3);
  endtask

  task automatic do_load_and_hit(input int lvl, input int x, input int y);
    hit_exp_t e;
    int n, lat;
    bit seen;
    tick();
    loadLevel = 1'b1;
    levelSel  = LVL_W'(lvl);
    hitReq    = 1'b1;
    hitX      = PIX_W'(x);
    hitY      = PIX_W'(y);
    tick();
    loadLevel = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    check("load_busy_cycles_pending_hit", n, 48);
    model_load(lvl);
    check("giftsLeft_after_load", int'(giftsLeft), gifts_m);
    model_hit(x, y, e);
    hit_q.push_back(e);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      tick();
      lat++;
      if (hitAck) seen = 1;
    end
    hitReq = 1'b0;
    check("pending_hit_ack_latency", lat, 3);
  endtask

  task automatic random_gift_hit();
    int cells[$];
    int k;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 8; c++)
        if (gm[r][c] == T_GF) cells.push_back(r*8 + c);
    if (cells.size() != 0 && $urandom_range(0, 1) == 1) begin
      k = cells[$urandom_range(0, cells.size() - 1)];
      do_hit((k % 8)*80 + int'($urandom_range(0, 79)), (k / 8)*80 + int'($urandom_range(0, 79)));
    end else begin
      do_hit(int'($urandom_range(0, 719)), int'($urandom_range(0, 539)));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0; pixelX = '0; pixelY = '0; hitX = '0; hitY = '0;
    loadLevel = 1'b0; levelSel = '0; hitReq = 1'b0;
    model_clear();
    repeat (3) tick();
    check("reset_Tile_type", int'(Tile_type), 0);
    check("reset_offsetX", int'(offsetX), 0);
    check("reset_offsetY", int'(offsetY), 0);
    check("reset_giftsLeft", int'(giftsLeft), 0);
    check("reset_hitAck", int'(hitAck), 0);
    check("reset_giftCollected", int'(giftCollected), 0);
    check("reset_busy", int'(busy), 0);
    resetN = 1'b1;

    // Empty grid lookup.
    show(100, 90);

    // Level 0 load and display.
    do_load(0);
    show(250, 175);
    show(0, 400);
    sweep();

    // Gift hit, then floor hit.
    do_hit(270, 200);
    show(250, 175);
    do_hit(10, 410);
    sweep();

    // Load wins over a same-cycle hit; hit serviced afterwards.
    do_load_and_hit(0, 270, 200);
    show(700, 10);
    sweep();

    // Reset in the middle of a load.
    tick();
    loadLevel = 1'b1;
    levelSel  = LVL_W'($urandom_range(0, 3));
    tick();
    loadLevel = 1'b0;
    repeat (20) tick();
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    model_clear();
    check("midload_reset_giftsLeft", int'(giftsLeft), 0);
    check("midload_reset_busy", int'(busy), 0);
    sweep();

    // Randomised mix of loads, hits and pixel lookups.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0:       do_load(int'($urandom_range(0, 3)));
        1, 2, 3: random_gift_hit();
        4:       sweep();
        default: begin
          for (int j = 0; j < 8; j++) begin
            tick();
            drive_pix(int'($urandom_range(0, 759)), int'($urandom_range(0, 559)), 1'b0);
          end
          tick();
        end
      endcase
    end

    repeat (4) tick();
    check("disp_queue_drained", int'(disp_q.size()), 0);
    check("hit_queue_drained", int'(hit_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
